// File: rtl/uart_word_sender.sv
// Word-to-byte serialiser feeding a UART transmitter: small word FIFO in front of an
// IDLE/START/WAIT sequencer that emits each word LSB byte first, paced by tx_done.
module uart_word_sender #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          word_valid,
  input  logic [DATA_WIDTH-1:0]         word_in,
  output logic                          word_ready,
  input  logic                          tx_done,
  output logic                          tx_start,
  output logic [BYTE_WIDTH-1:0]         tx_byte,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                  push, pop;
  logic                  last_byte;

  // Ready comes only from the registered count, so a same-cycle pop never frees a slot early.
  assign word_ready = (count_q != FULL_CNT);
  assign push       = word_valid && word_ready;
  assign pop        = (state_q == ST_IDLE) && (count_q != '0);
  assign last_byte  = (byte_idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shreg_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= word_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) state_d = last_byte ? ST_IDLE : ST_START;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    shreg_d    = shreg_q;
    byte_idx_d = byte_idx_q;
    if (pop) begin
      shreg_d    = fifo_mem[rd_ptr_q];
      byte_idx_d = '0;
    end else if ((state_q == ST_WAIT) && tx_done && !last_byte) begin
      shreg_d    = shreg_q >> BYTE_WIDTH;
      byte_idx_d = byte_idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    tx_start = (state_q == ST_START);
    busy     = (state_q != ST_IDLE) || (count_q != '0);
  end

  assign tx_byte    = shreg_q[BYTE_WIDTH-1:0];
  assign fifo_count = count_q;

endmodule
